uart_tx_serializer: RTL and testbench
=====================================

Name: uart_tx_serializer

Overview:
Transmit stage directly downstream of the baud-tick generator. It consumes the one-cycle baud pulse (`out` of the clock stage) and serializes a byte onto the UART line: start bit, data bits LSB-first, optional parity, then stop bit(s). A valid/ready handshake on the parallel side lets a host FSM or FIFO push one frame at a time.

Parameters:
- DATA_BITS, 8, number of data bits per frame (5..8)
- PARITY_EN, 0, 1 = append a parity bit after the data bits
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN=0)
- STOP_BITS, 1, number of stop bit periods (1 or 2)

Ports:
- Clk  input  1  system clock
- Rst  input  1  reset; asynchronous, active-high
- BaudTick  input  1  one-Clk pulse per bit period, from the baud generator
- TxData  input  DATA_BITS  byte to send; sampled on accept
- TxValid  input  1  host has a byte
- TxReady  output  1  block can accept; high only in IDLE
- Tx  output  1  serial line, idle high
- Busy  output  1  high from accept until the frame completes
- TxDone  output  1  one-Clk pulse when the last stop bit ends

Behaviour:
- Reset (async, Rst=1): state=IDLE, Tx=1, TxReady=1, Busy=0, TxDone=0, shift register=0, counters=0. Asserting Rst mid-frame aborts the frame and forces Tx=1 immediately, with no partial-frame completion.
- All outputs are registered. Tx changes only on the Clk edge where BaudTick=1, except on reset.
- Accept: TxValid && TxReady at a Clk edge latches TxData into the shift register, clears TxReady and sets Busy on the same edge, and enters SYNC.
- States:
  - IDLE: Tx=1. Accept goes to SYNC. BaudTick is ignored.
  - SYNC: Tx=1. Waits for the next BaudTick; on it, Tx=0 and the state goes to START. A BaudTick in the same cycle as the accept is not counted; SYNC waits for a later tick. This keeps the start bit a full period long.
  - START: on BaudTick, Tx=shift[0], shift right, bit_cnt=1, go to DATA.
  - DATA: on BaudTick, if bit_cnt<DATA_BITS then Tx=shift[0], shift, bit_cnt++. Otherwise Tx=parity and go to PARITY if PARITY_EN, else Tx=1 and go to STOP with stop_cnt=1.
  - PARITY: on BaudTick, Tx=1, stop_cnt=1, go to STOP.
  - STOP: on BaudTick, if stop_cnt<STOP_BITS then stop_cnt++. Otherwise go to IDLE, TxReady=1, Busy=0, and pulse TxDone for one cycle.
- Parity is computed from the latched byte at accept, not the shifting copy. Even parity = XOR of the data bits; odd parity = its inverse.
- Widths: bit_cnt is 4 bits. stop_cnt is 2 bits. Neither counter wraps within a legal configuration.
- Frame length is exactly 1 + DATA_BITS + PARITY_EN + STOP_BITS tick periods, plus a SYNC wait of 1..N Clk cycles.
- TxValid while not ready is held off and not dropped. TxData may change freely while TxReady=0.
- Back-to-back: a new accept is possible in the same cycle TxReady rises (the IDLE cycle). The next start bit then begins on the following BaudTick.
- A BaudTick present on consecutive Clk cycles is legal: each tick advances one bit.

Decomposition:
- Shared uart package holds:
  - the state enum (IDLE, SYNC, START, DATA, PARITY, STOP) as 3-bit localparams
  - the IDLE_LEVEL=1 constant
  - the frame-length helper function, reused later by the RX stage
- No sub-module. The parity function lives in the package. The block instantiates alongside the existing baud generator at the top level, with BaudTick wired to its tick output.

Test Plan:
- Reset mid-frame: send 0x3C, assert Rst during the 4th data bit → Tx=1 within the same cycle, TxReady=1, no TxDone. A subsequent 0x3C is sent intact.
- Basic 8N1: TxData=0xA5, one TxValid pulse, BaudTick every 16 Clk → Tx sequence 0, 1,0,1,0,0,1,0,1, then 1. TxDone pulses once, 160 Clk after the start bit begins. Busy=1 throughout.
- Even and odd parity: PARITY_EN=1 with 0xA5 → parity bit 0 (even) or 1 with PARITY_ODD=1. With 0x01 → parity bit 1 (even).
- 2 stop bits, 7 data bits: TxData=0x55 → 7 data bits 1010101, then Tx high for exactly 2 tick periods before TxReady rises.
- Tick-on-accept: assert TxValid on the exact cycle BaudTick=1 → start bit begins on the next tick, not that one, and is a full period long.
- Back-to-back with TxValid held high and data 0x11 then 0x22 → second start bit begins on the first tick after TxDone. No idle gap beyond one SYNC wait, and no dropped byte.

Source files
------------

// File: rtl/uart_tx_serializer_pkg.sv
// Shared UART definitions: transmit FSM states, line idle level, parity and frame-length helpers.
// The RX stage reuses the frame-length and parity helpers.
package uart_tx_serializer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } state_t;

    localparam logic IDLE_LEVEL = 1'b1;

    // Whole-frame length in baud periods: start + data + optional parity + stop bits.
    function automatic int unsigned frame_ticks(input int unsigned data_bits,
                                                input int unsigned parity_en,
                                                input int unsigned stop_bits);
        return 1 + data_bits + parity_en + stop_bits;
    endfunction

    // Even parity is the XOR of the low data_bits bits; odd parity inverts it.
    function automatic logic calc_parity(input logic [7:0]  data,
                                         input int unsigned data_bits,
                                         input logic        odd);
        logic p;
        p = odd;
        for (int i = 0; i < 8; i++) begin
            if (i < int'(data_bits)) begin
                p = p ^ data[i];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Parallel-side handshake and status bundle between a host (FIFO/FSM) and the UART transmitter.
interface uart_tx_serializer_if #(
    parameter int DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 tx;
    logic                 busy;
    logic                 tx_done;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  tx,
        input  busy,
        input  tx_done
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output tx,
        output busy,
        output tx_done
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: frames one accepted word as start, LSB-first data, optional parity
// and stop bits, advancing one bit per baud tick. Every output is a register.
module uart_tx_serializer
    import uart_tx_serializer_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  baud_tick,
    uart_tx_serializer_if.slave   bus
);

    state_t               state_reg,    state_next;
    logic [DATA_BITS-1:0] shift_reg,    shift_next;
    logic [3:0]           bit_cnt_reg,  bit_cnt_next;
    logic [1:0]           stop_cnt_reg, stop_cnt_next;
    logic                 parity_reg,   parity_next;
    logic                 tx_reg,       tx_next;
    logic                 ready_reg,    ready_next;
    logic                 busy_reg,     busy_next;
    logic                 done_reg,     done_next;

    logic       accept;
    logic       data_last;
    logic       stop_last;
    logic [7:0] data_ext;

    assign accept    = bus.tx_valid && ready_reg;
    assign data_last = (bit_cnt_reg >= 4'(DATA_BITS));
    assign stop_last = (stop_cnt_reg >= 2'(STOP_BITS));

    always_comb begin
        data_ext                = '0;
        data_ext[DATA_BITS-1:0] = bus.tx_data;
    end

    // State and datapath registers; reset aborts any frame and parks the line high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            shift_reg    <= '0;
            bit_cnt_reg  <= '0;
            stop_cnt_reg <= '0;
            parity_reg   <= 1'b0;
            tx_reg       <= IDLE_LEVEL;
            ready_reg    <= 1'b1;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            shift_reg    <= shift_next;
            bit_cnt_reg  <= bit_cnt_next;
            stop_cnt_reg <= stop_cnt_next;
            parity_reg   <= parity_next;
            tx_reg       <= tx_next;
            ready_reg    <= ready_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE:   if (accept)    state_next = ST_SYNC;
            ST_SYNC:   if (baud_tick) state_next = ST_START;
            ST_START:  if (baud_tick) state_next = ST_DATA;
            ST_DATA: begin
                if (baud_tick && data_last) begin
                    state_next = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: if (baud_tick) state_next = ST_STOP;
            ST_STOP:   if (baud_tick && stop_last) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Next values for the registered outputs and datapath; TxDone defaults low so it only pulses.
    always_comb begin
        shift_next    = shift_reg;
        bit_cnt_next  = bit_cnt_reg;
        stop_cnt_next = stop_cnt_reg;
        parity_next   = parity_reg;
        tx_next       = tx_reg;
        ready_next    = ready_reg;
        busy_next     = busy_reg;
        done_next     = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                tx_next = IDLE_LEVEL;
                if (accept) begin
                    shift_next    = bus.tx_data;
                    parity_next   = calc_parity(data_ext, DATA_BITS, PARITY_ODD != 0);
                    bit_cnt_next  = '0;
                    stop_cnt_next = '0;
                    ready_next    = 1'b0;
                    busy_next     = 1'b1;
                end
            end
            ST_SYNC: begin
                if (baud_tick) tx_next = 1'b0;
            end
            ST_START: begin
                if (baud_tick) begin
                    tx_next      = shift_reg[0];
                    shift_next   = shift_reg >> 1;
                    bit_cnt_next = 4'd1;
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    if (!data_last) begin
                        tx_next      = shift_reg[0];
                        shift_next   = shift_reg >> 1;
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end else if (PARITY_EN != 0) begin
                        tx_next = parity_reg;
                    end else begin
                        tx_next       = IDLE_LEVEL;
                        stop_cnt_next = 2'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (baud_tick) begin
                    tx_next       = IDLE_LEVEL;
                    stop_cnt_next = 2'd1;
                end
            end
            ST_STOP: begin
                if (baud_tick) begin
                    if (!stop_last) begin
                        stop_cnt_next = stop_cnt_reg + 2'd1;
                    end else begin
                        ready_next = 1'b1;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                    end
                end
            end
            default: begin
                tx_next    = IDLE_LEVEL;
                ready_next = 1'b1;
                busy_next  = 1'b0;
            end
        endcase
    end

    assign bus.tx       = tx_reg;
    assign bus.tx_ready = ready_reg;
    assign bus.busy     = busy_reg;
    assign bus.tx_done  = done_reg;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: four configurations (8N1, 8E1, 8O1, 7N2) share clock, reset and
// baud tick; each frame is compared bit-by-bit and cycle-by-cycle against a frame model.
module tb_uart_tx_serializer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic baud_tick = 1'b0;
    logic tick_en = 1'b0;
    int   tick_period = 16;
    int   tick_cnt = 0;

    int checks = 0;
    int errors = 0;

    logic       valid [4];
    logic [7:0] data  [4];

    int cfg_bits [4] = '{8, 8, 8, 7};
    int cfg_par  [4] = '{0, 1, 1, 0};
    int cfg_odd  [4] = '{0, 0, 1, 0};
    int cfg_stop [4] = '{1, 1, 1, 2};

    always #5 clk = ~clk;

    // Baud tick: one-cycle pulse every tick_period clocks, changed on the falling edge.
    always @(negedge clk) begin
        if (!tick_en) begin
            baud_tick <= 1'b0;
            tick_cnt  <= 0;
        end else if (tick_cnt >= tick_period - 1) begin
            baud_tick <= 1'b1;
            tick_cnt  <= 0;
        end else begin
            baud_tick <= 1'b0;
            tick_cnt  <= tick_cnt + 1;
        end
    end

    uart_tx_serializer_if #(.DATA_BITS(8)) bus0 ();
    uart_tx_serializer_if #(.DATA_BITS(8)) bus1 ();
    uart_tx_serializer_if #(.DATA_BITS(8)) bus2 ();
    uart_tx_serializer_if #(.DATA_BITS(7)) bus3 ();

    uart_tx_serializer #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .bus(bus0));
    uart_tx_serializer #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .bus(bus1));
    uart_tx_serializer #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .bus(bus2));
    uart_tx_serializer #(.DATA_BITS(7), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_7n2 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .bus(bus3));

    assign bus0.tx_valid = valid[0];
    assign bus1.tx_valid = valid[1];
    assign bus2.tx_valid = valid[2];
    assign bus3.tx_valid = valid[3];
    assign bus0.tx_data  = data[0];
    assign bus1.tx_data  = data[1];
    assign bus2.tx_data  = data[2];
    assign bus3.tx_data  = data[3][6:0];

    logic [3:0] tx_v, ready_v, busy_v, done_v;
    assign tx_v    = {bus3.tx,       bus2.tx,       bus1.tx,       bus0.tx};
    assign ready_v = {bus3.tx_ready, bus2.tx_ready, bus1.tx_ready, bus0.tx_ready};
    assign busy_v  = {bus3.busy,     bus2.busy,     bus1.busy,     bus0.busy};
    assign done_v  = {bus3.tx_done,  bus2.tx_done,  bus1.tx_done,  bus0.tx_done};

    // Reference frame: line level for each baud period after the start tick, in order.
    function automatic int build_frame(input int idx, input logic [7:0] b, output logic [15:0] v);
        int   n;
        logic p;
        v = '1;
        n = 0;
        p = 1'b0;
        v[n] = 1'b0;
        n++;
        for (int i = 0; i < cfg_bits[idx]; i++) begin
            v[n] = b[i];
            p    = p ^ b[i];
            n++;
        end
        if (cfg_par[idx] != 0) begin
            v[n] = (cfg_odd[idx] != 0) ? ~p : p;
            n++;
        end
        for (int s = 0; s < cfg_stop[idx]; s++) begin
            v[n] = 1'b1;
            n++;
        end
        return n;
    endfunction

    // Present a word on one DUT; optionally line the accept edge up with a baud tick.
    task automatic do_accept(input int idx, input logic [7:0] b, input bit align, input bit hold);
        int g;
        @(negedge clk); #1;
        if (align) begin
            g = 0;
            while (!baud_tick && g < 64) begin
                @(negedge clk); #1;
                g++;
            end
            checks++;
            if (!baud_tick) begin
                errors++;
                $display("FAIL align_tick dut%0d: tick=%b, required 1 within 64 cycles", idx, baud_tick);
            end
        end
        checks++;
        if (ready_v[idx] !== 1'b1) begin
            errors++;
            $display("FAIL ready_before_accept dut%0d: ready=%b, required 1", idx, ready_v[idx]);
        end
        data[idx]  = b;
        valid[idx] = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ready_v[idx] !== 1'b0 || busy_v[idx] !== 1'b1 || tx_v[idx] !== 1'b1) begin
            errors++;
            $display("FAIL accept dut%0d: ready=%b busy=%b tx=%b, required ready=0 busy=1 tx=1",
                     idx, ready_v[idx], busy_v[idx], tx_v[idx]);
        end
        @(negedge clk); #1;
        if (!hold) valid[idx] = 1'b0;
        data[idx] = 8'($urandom);
    endtask

    // Follow one accepted frame to completion, comparing the line every cycle against the model.
    task automatic run_frame(input int idx, input logic [7:0] b, output int wait_cycles);
        logic [15:0] v;
        int   n, cyc, total;
        logic tk, cur;
        n = build_frame(idx, b, v);
        cur = 1'b1;
        total = 0;
        wait_cycles = 0;
        for (int j = 0; j <= n; j++) begin
            cyc = 0;
            tk  = 1'b0;
            while (!tk) begin
                @(posedge clk);
                tk = baud_tick;
                #1;
                cyc++;
                if (!tk) begin
                    checks++;
                    if (tx_v[idx] !== cur || ready_v[idx] !== 1'b0 || busy_v[idx] !== 1'b1 ||
                        done_v[idx] !== 1'b0) begin
                        errors++;
                        $display("FAIL hold dut%0d period%0d: tx=%b ready=%b busy=%b done=%b, required tx=%b ready=0 busy=1 done=0",
                                 idx, j, tx_v[idx], ready_v[idx], busy_v[idx], done_v[idx], cur);
                    end
                    if (cyc > 64) begin
                        errors++;
                        $display("FAIL tick_timeout dut%0d period%0d: no tick in %0d cycles", idx, j, cyc);
                        return;
                    end
                end
            end
            if (j == 0) wait_cycles = cyc;
            else        total += cyc;
            if (j < n) begin
                cur = v[j];
                checks++;
                if (tx_v[idx] !== cur || ready_v[idx] !== 1'b0 || busy_v[idx] !== 1'b1 ||
                    done_v[idx] !== 1'b0) begin
                    errors++;
                    $display("FAIL bit dut%0d period%0d: tx=%b ready=%b busy=%b done=%b, required tx=%b ready=0 busy=1 done=0",
                             idx, j, tx_v[idx], ready_v[idx], busy_v[idx], done_v[idx], cur);
                end
            end else begin
                checks++;
                if (tx_v[idx] !== 1'b1 || ready_v[idx] !== 1'b1 || busy_v[idx] !== 1'b0 ||
                    done_v[idx] !== 1'b1) begin
                    errors++;
                    $display("FAIL frame_end dut%0d: tx=%b ready=%b busy=%b done=%b, required tx=1 ready=1 busy=0 done=1",
                             idx, tx_v[idx], ready_v[idx], busy_v[idx], done_v[idx]);
                end
            end
        end
        checks++;
        if (total != n * tick_period) begin
            errors++;
            $display("FAIL frame_length dut%0d: %0d cycles, required %0d", idx, total, n * tick_period);
        end
        @(posedge clk); #1;
        checks++;
        if (done_v[idx] !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse dut%0d: done=%b one cycle later, required 0", idx, done_v[idx]);
        end
        $display("frame dut%0d data=0x%02h periods=%0d tick=%0d sync_wait=%0d cycles=%0d",
                 idx, b, n, tick_period, wait_cycles, total);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (tx_v[i] !== 1'b1 || ready_v[i] !== 1'b1 || busy_v[i] !== 1'b0 || done_v[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset dut%0d: tx=%b ready=%b busy=%b done=%b, required 1 1 0 0",
                         i, tx_v[i], ready_v[i], busy_v[i], done_v[i]);
            end
        end
        @(negedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic_8n1();
        int w;
        tick_period = 16;
        do_accept(0, 8'hA5, 1'b0, 1'b0);
        run_frame(0, 8'hA5, w);
    endtask

    task automatic test_parity();
        int w;
        tick_period = 16;
        do_accept(1, 8'hA5, 1'b0, 1'b0);
        run_frame(1, 8'hA5, w);
        do_accept(2, 8'hA5, 1'b0, 1'b0);
        run_frame(2, 8'hA5, w);
        do_accept(1, 8'h01, 1'b0, 1'b0);
        run_frame(1, 8'h01, w);
    endtask

    task automatic test_two_stop();
        int w;
        tick_period = 16;
        do_accept(3, 8'h55, 1'b0, 1'b0);
        run_frame(3, 8'h55, w);
    endtask

    task automatic test_tick_on_accept();
        int w;
        logic [7:0] b;
        tick_period = 16;
        b = 8'($urandom);
        do_accept(0, b, 1'b1, 1'b0);
        run_frame(0, b, w);
        checks++;
        if (w != tick_period) begin
            errors++;
            $display("FAIL tick_on_accept: start after %0d cycles, required %0d", w, tick_period);
        end
    endtask

    task automatic test_back_to_back();
        int w;
        tick_period = 16;
        do_accept(0, 8'h11, 1'b0, 1'b1);
        data[0] = 8'h22;
        run_frame(0, 8'h11, w);
        checks++;
        if (ready_v[0] !== 1'b0 || busy_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: ready=%b busy=%b, required ready=0 busy=1", ready_v[0], busy_v[0]);
        end
        @(negedge clk); #1;
        valid[0] = 1'b0;
        run_frame(0, 8'h22, w);
        checks++;
        if (w != tick_period - 1) begin
            errors++;
            $display("FAIL b2b_gap: start %0d cycles after accept, required %0d", w, tick_period - 1);
        end
    endtask

    task automatic test_reset_mid_frame();
        int seen, g, w;
        tick_period = 16;
        do_accept(0, 8'h3C, 1'b0, 1'b0);
        seen = 0;
        g = 0;
        while (seen < 5 && g < 400) begin
            @(posedge clk);
            if (baud_tick) seen++;
            #1;
            g++;
        end
        checks++;
        if (seen < 5) begin
            errors++;
            $display("FAIL midreset_ticks: saw %0d ticks, required 5", seen);
        end
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (tx_v[0] !== 1'b1 || ready_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL midreset dut0: tx=%b ready=%b busy=%b done=%b, required 1 1 0 0",
                     tx_v[0], ready_v[0], busy_v[0], done_v[0]);
        end
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            checks++;
            if (done_v[0] !== 1'b0 || tx_v[0] !== 1'b1) begin
                errors++;
                $display("FAIL midreset_after dut0: done=%b tx=%b, required done=0 tx=1", done_v[0], tx_v[0]);
            end
        end
        do_accept(0, 8'h3C, 1'b0, 1'b0);
        run_frame(0, 8'h3C, w);
    endtask

    task automatic test_random();
        int idx, w, gap;
        logic [7:0] b;
        for (int k = 0; k < 24; k++) begin
            idx = int'($urandom_range(0, 3));
            tick_period = int'($urandom_range(1, 12));
            b = 8'($urandom);
            gap = int'($urandom_range(0, 5));
            repeat (gap) @(negedge clk);
            do_accept(idx, b, 1'b0, 1'b0);
            run_frame(idx, b, w);
            checks++;
            if (w < 1 || w > tick_period) begin
                errors++;
                $display("FAIL sync_wait dut%0d: %0d cycles, required 1..%0d", idx, w, tick_period);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            valid[i] = 1'b0;
            data[i]  = 8'h00;
        end
        tick_en = 1'b1;
        test_reset();
        test_basic_8n1();
        test_parity();
        test_two_stop();
        test_tick_on_accept();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
